// File: rtl/sram_puf_eval_if.sv
// Read-port, start/status and result bundle between the PUF evaluation stage
// and its surroundings (capture RAM, golden ROM, debug/reporting logic).
interface sram_puf_eval_if #(
  parameter int ADDR_W = 6
);
  logic              start;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        puf_rdata;
  logic [7:0]        gold_rdata;
  logic              busy;
  logic              done;
  logic [9:0]        hw;
  logic [9:0]        hd;
  logic              match;

  modport master (
    output start, puf_rdata, gold_rdata,
    input  rd_addr, busy, done, hw, hd, match
  );

  modport slave (
    input  start, puf_rdata, gold_rdata,
    output rd_addr, busy, done, hw, hd, match
  );
endinterface

// File: rtl/sram_puf_eval.sv
// SRAM PUF frame evaluation: streams the captured frame and the golden
// fingerprint, reporting Hamming weight, Hamming distance and a match flag.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; results hold the last evaluation
// S_READ  | issuing addresses 0..NBYTES-1, accumulating returned bytes
// S_DRAIN | address held at NBYTES-1 until the read pipeline is empty
// S_DONE  | results valid, done pulses for this single cycle
module sram_puf_eval #(
  parameter int NBYTES       = 64,
  parameter int ADDR_W       = 6,
  parameter int HD_THRESHOLD = 51
) (
  input logic            uprocessor_clk,
  input logic            rst,
  sram_puf_eval_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [9:0]        acc_hw;
  logic [9:0]        acc_hd;
  logic [9:0]        hw_q;
  logic [9:0]        hd_q;
  logic              match_q;
  logic              last_addr;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

  assign last_addr = (rd_addr == ADDR_W'(NBYTES - 1));

  always_ff @(posedge uprocessor_clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_READ;
      S_READ:  if (last_addr) state_nxt = S_DRAIN;
      // Leave only once the byte for the final address has been accumulated.
      S_DRAIN: if (!rd_valid) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge uprocessor_clk or posedge rst) begin
    if (rst) begin
      rd_addr  <= '0;
      rd_valid <= 1'b0;
      acc_hw   <= '0;
      acc_hd   <= '0;
      hw_q     <= '0;
      hd_q     <= '0;
      match_q  <= 1'b0;
    end else begin
      rd_valid <= (state == S_READ);
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            rd_addr <= '0;
            acc_hw  <= '0;
            acc_hd  <= '0;
          end
        end
        S_READ: begin
          if (!last_addr) rd_addr <= rd_addr + ADDR_W'(1);
        end
        S_DRAIN: begin
          if (!rd_valid) begin
            hw_q    <= acc_hw;
            hd_q    <= acc_hd;
            match_q <= (acc_hd <= 10'(HD_THRESHOLD));
          end
        end
        default: ;
      endcase
      // rd_valid is only ever set in the cycles following READ, never in IDLE.
      if (rd_valid) begin
        acc_hw <= acc_hw + {6'd0, popcount8(bus.puf_rdata)};
        acc_hd <= acc_hd + {6'd0, popcount8(bus.puf_rdata ^ bus.gold_rdata)};
      end
    end
  end

  assign bus.rd_addr = rd_addr;
  assign bus.busy    = (state != S_IDLE);
  assign bus.done    = (state == S_DONE);
  assign bus.hw      = hw_q;
  assign bus.hd      = hd_q;
  assign bus.match   = match_q;

endmodule
